// File: rtl/mux2.sv
// Purpose : 2:1 data mux with registered side-outputs (y_q, sel_q) and a select-toggle counter.
// Latency : y is combinational (0 cycles); y_q / sel_q / toggle_cnt update 1 clk after their inputs.
// Backpressure: none; the mux output is always valid and the side-outputs never stall.
//
// Ports:
//   clk        - clock for the side-output registers only (may be left unconnected)
//   rst_n      - asynchronous active-low reset of the side-output registers
//   d0, d1     - WIDTH-bit data inputs, selected by s=0 / s=1
//   s          - select
//   y          - combinational mux output, independent of clk/rst_n/internal state
//   y_q        - y registered on the rising clk edge
//   sel_q      - s registered on the rising clk edge
//   toggle_cnt - 16-bit saturating count of edges where s differed from sel_q

module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             sel_q,
    output logic [15:0]      toggle_cnt
);

    // The conditional operator is used deliberately: with s unknown it merges
    // d0/d1 bitwise, giving the common value where they agree and X elsewhere.
    logic [WIDTH-1:0] w_y;
    assign w_y = s ? d1 : d0;
    assign y   = w_y;

    logic [WIDTH-1:0] r_y_q;
    logic             r_sel_q;
    logic [15:0]      r_toggle_cnt;

    // A toggle is a change of s relative to the value captured on the previous edge.
    logic w_toggle;
    logic w_cnt_sat;
    assign w_toggle  = s ^ r_sel_q;
    assign w_cnt_sat = &r_toggle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_q        <= '0;
            r_sel_q      <= 1'b0;
            r_toggle_cnt <= 16'h0000;
        end else begin
            r_y_q   <= w_y;
            r_sel_q <= s;
            if (w_toggle && !w_cnt_sat) begin
                r_toggle_cnt <= r_toggle_cnt + 16'h0001;
            end
        end
    end

    // Side-outputs are taps only; nothing here feeds back into y.
    assign y_q        = r_y_q;
    assign sel_q      = r_sel_q;
    assign toggle_cnt = r_toggle_cnt;

endmodule

// File: tb/tb_mux2.sv
// Purpose : self-checking bench for mux2 at WIDTH=32, 5 and 1 with a scoreboard queue.
// Latency : combinational checks after a settle delay; registered checks 1 ns after the clk edge.
// Backpressure: not applicable.

module tb_mux2;

    logic clk     = 1'b0;
    logic clk_run = 1'b0;
    logic rst_n   = 1'b1;

    always #5 clk = clk_run ? ~clk : clk;

    // WIDTH=32 instance
    logic [31:0] d0_32, d1_32, y_32, y_q_32;
    logic        s_32, sel_q_32;
    logic [15:0] cnt_32;

    mux2 #(32) u_mux32 (
        .clk(clk), .rst_n(rst_n), .d0(d0_32), .d1(d1_32), .s(s_32),
        .y(y_32), .y_q(y_q_32), .sel_q(sel_q_32), .toggle_cnt(cnt_32)
    );

    // WIDTH=5 instance
    logic [4:0]  d0_5, d1_5, y_5, y_q_5;
    logic        s_5, sel_q_5;
    logic [15:0] cnt_5;

    mux2 #(5) u_mux5 (
        .clk(clk), .rst_n(rst_n), .d0(d0_5), .d1(d1_5), .s(s_5),
        .y(y_5), .y_q(y_q_5), .sel_q(sel_q_5), .toggle_cnt(cnt_5)
    );

    // WIDTH=1 instance
    logic        d0_1, d1_1, y_1, y_q_1;
    logic        s_1, sel_q_1;
    logic [15:0] cnt_1;

    mux2 #(1) u_mux1 (
        .clk(clk), .rst_n(rst_n), .d0(d0_1), .d1(d1_1), .s(s_1),
        .y(y_1), .y_q(y_q_1), .sel_q(sel_q_1), .toggle_cnt(cnt_1)
    );

    logic [31:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic cmp(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            vectors++;
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // Drive a WIDTH=32 vector and queue its expected y.
    task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic sel,
                           input logic [31:0] expect_y);
        d0_32 = a; d1_32 = b; s_32 = sel;
        exp_q.push_back(expect_y);
    endtask

    task automatic drive5(input logic [4:0] a, input logic [4:0] b, input logic sel,
                          input logic [4:0] expect_y);
        d0_5 = a; d1_5 = b; s_5 = sel;
        exp_q.push_back({27'b0, expect_y});
    endtask

    // Safety net so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] exp_cnt;
    logic        prev_sel;
    logic [3:0]  spat;
    logic [1:0]  pair;
    logic [31:0] exp_y;

    initial begin
        d0_32 = '0; d1_32 = '0; s_32 = 1'b0;
        d0_5  = '0; d1_5  = '0; s_5  = 1'b0;
        d0_1  = 1'b0; d1_1 = 1'b0; s_1 = 1'b0;

        // Asynchronous reset with no clock running.
        #1 rst_n = 1'b0;
        #1;
        exp_q.push_back(32'h0); cmp("rst_y_q", y_q_32);
        exp_q.push_back(32'h0); cmp("rst_sel_q", {31'b0, sel_q_32});
        exp_q.push_back(32'h0); cmp("rst_cnt", {16'b0, cnt_32});

        // WIDTH=32 directed patterns, no clock.
        drive32(32'h12345678, 32'hABCDEF01, 1'b0, 32'h12345678); #10 cmp("w32_s0", y_32);
        drive32(32'h12345678, 32'hABCDEF01, 1'b1, 32'hABCDEF01); #10 cmp("w32_s1", y_32);
        drive32(32'h55555555, 32'hAAAAAAAA, 1'b0, 32'h55555555); #10 cmp("w32_alt_s0", y_32);
        drive32(32'h55555555, 32'hAAAAAAAA, 1'b1, 32'hAAAAAAAA); #10 cmp("w32_alt_s1", y_32);
        drive32(32'h00000000, 32'h00000000, 1'b0, 32'h00000000); #10 cmp("w32_zero_s0", y_32);
        drive32(32'h00000000, 32'h00000000, 1'b1, 32'h00000000); #10 cmp("w32_zero_s1", y_32);
        drive32(32'hFFFFFFFF, 32'h00000000, 1'b0, 32'hFFFFFFFF); #10 cmp("w32_ones_s0", y_32);

        // WIDTH=5 directed patterns.
        drive5(5'b00000, 5'b11111, 1'b0, 5'h00); #1 cmp("w5_s0", {27'b0, y_5});
        drive5(5'b00000, 5'b11111, 1'b1, 5'h1F); #1 cmp("w5_s1", {27'b0, y_5});
        drive5(5'h0A, 5'h19, 1'b0, 5'h0A);       #1 cmp("w5_b_s0", {27'b0, y_5});
        drive5(5'h0A, 5'h19, 1'b1, 5'h19);       #1 cmp("w5_b_s1", {27'b0, y_5});

        // WIDTH=1 exhaustive: expected is the bit of {d1,d0} indexed by s.
        for (int k = 0; k < 8; k++) begin
            d0_1 = k[0]; d1_1 = k[1]; s_1 = k[2];
            pair = {d1_1, d0_1};
            exp_q.push_back({31'b0, pair[s_1]});
            #1 cmp("w1_combo", {31'b0, y_1});
        end

        // Clocked: registers must hold reset values while rst_n is low.
        clk_run = 1'b1;
        d0_32 = 32'hDEADBEEF; d1_32 = 32'hCAFEF00D; s_32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(32'h0); cmp("inrst_y_q", y_q_32);
        exp_q.push_back(32'h0); cmp("inrst_cnt", {16'b0, cnt_32});
        exp_q.push_back(32'hCAFEF00D); cmp("inrst_y", y_32);

        @(negedge clk);
        s_32  = 1'b0;
        rst_n = 1'b1;

        // s pattern 1,0,1,1: three toggles then a hold.
        spat     = 4'b1101;
        prev_sel = 1'b0;
        exp_cnt  = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d0_32 = 32'h10000000 + 32'(i);
            d1_32 = 32'hF0000000 + 32'(i);
            s_32  = spat[i];
            exp_y = s_32 ? d1_32 : d0_32;
            if (s_32 != prev_sel && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h0001;
            prev_sel = s_32;
            exp_q.push_back(exp_y);
            exp_q.push_back({16'b0, exp_cnt});
            exp_q.push_back({31'b0, prev_sel});
            @(posedge clk); #1;
            cmp("step_y_q", y_q_32);
            cmp("step_cnt", {16'b0, cnt_32});
            cmp("step_sel_q", {31'b0, sel_q_32});
        end

        // Drive the counter to saturation: 3 + 65532 toggles = 65535.
        for (int i = 0; i < 65532; i++) begin
            @(negedge clk);
            s_32 = ~s_32;
        end
        @(posedge clk); #1;
        exp_q.push_back(32'h0000FFFF); cmp("sat_reach", {16'b0, cnt_32});

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s_32 = ~s_32;
            @(posedge clk); #1;
            exp_q.push_back(32'h0000FFFF); cmp("sat_hold", {16'b0, cnt_32});
        end

        // Mid-cycle reset clears everything immediately; y keeps following the inputs.
        @(negedge clk);
        d0_32 = 32'h0F0F0F0F; d1_32 = 32'h3C3C3C3C; s_32 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(32'h0); cmp("midrst_cnt", {16'b0, cnt_32});
        exp_q.push_back(32'h0); cmp("midrst_sel_q", {31'b0, sel_q_32});
        exp_q.push_back(32'h0); cmp("midrst_y_q", y_q_32);
        exp_q.push_back(32'h0F0F0F0F); cmp("midrst_y", y_32);

        clk_run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
